// File: rtl/sr1_gpu_pkg.sv
// Shared definitions for the OLED frame path: FSM states, SSD1306 command bytes, framebuffer geometry.
// Pure declarations: no logic, no latency.
// Optional power-up sequence bytes are only referenced when OLED_INIT_SEQ_EN is defined.
package sr1_gpu_pkg;

  typedef enum logic [2:0] {IDLE, INIT, CMD, FETCH, WAIT, SHIFT, DONE} state_t;

  // Framebuffer geometry: 128x64 pixels, one 1024-byte half per displayed page set
  localparam int FB_COLS       = 128;
  localparam int FB_ROWS       = 64;
  localparam int FB_PAGE_BYTES = 1024;
  localparam int FB_ADDR_W     = $clog2(FB_PAGE_BYTES);

  // Addressing window preamble: column range then page range
  localparam logic [7:0] CMD_SET_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_SET_PAGE_ADDR = 8'h22;
  localparam logic [7:0] CMD_RANGE_START   = 8'h00;
  localparam int         CMD_LEN           = 6;

  // Power-up sequence: charge pump on, horizontal addressing, display on
  localparam logic [7:0] INIT_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] INIT_PUMP_ENABLE  = 8'h14;
  localparam logic [7:0] INIT_ADDR_MODE    = 8'h20;
  localparam logic [7:0] INIT_MODE_HORIZ   = 8'h00;
  localparam logic [7:0] INIT_DISPLAY_ON   = 8'hAF;
  localparam int         INIT_LEN          = 5;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [7:0] last_col,
                                          input logic [7:0] last_page);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD_SET_COL_ADDR;
      3'd1:    b = CMD_RANGE_START;
      3'd2:    b = last_col;
      3'd3:    b = CMD_SET_PAGE_ADDR;
      3'd4:    b = CMD_RANGE_START;
      default: b = last_page;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = INIT_CHARGE_PUMP;
      3'd1:    b = INIT_PUMP_ENABLE;
      3'd2:    b = INIT_ADDR_MODE;
      3'd3:    b = INIT_MODE_HORIZ;
      default: b = INIT_DISPLAY_ON;
    endcase
    return b;
  endfunction

  // Column-major framebuffer: byte address = col*8 + page, truncated to the buffer width
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [10:0] col, input logic [10:0] page);
    logic [13:0] sum;
    sum = {col, 3'b000} + {3'b000, page};
    return sum[FB_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte serialiser, MSB first: one setup cycle then 8 x (CLK_DIV high + CLK_DIV low).
// Latency: done_o is high in the last low cycle, 1 + 16*CLK_DIV cycles after load is taken.
// No backpressure: load_i is ignored while a byte is in flight.
module spi_byte_tx
  #(parameter int CLK_DIV = 2)
  (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       dc_i,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       dc_o
  );

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic       active_q, setup_q, sclk_q, mosi_q, dc_q;
  logic [6:0] shreg_q;
  logic [2:0] bit_q;
  logic [7:0] div_q;

  // End of the final low half-period of bit 7
  assign done_o = active_q && !setup_q && !sclk_q && (bit_q == 3'd7) && (div_q == DIV_LAST);
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign dc_o   = dc_q;

  // Bit/half-period sequencer; mosi only changes on the falling sclk transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      setup_q  <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      dc_q     <= 1'b0;
      shreg_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
    end else if (!active_q) begin
      if (load_i) begin
        active_q <= 1'b1;
        setup_q  <= 1'b1;
        mosi_q   <= byte_i[7];
        shreg_q  <= byte_i[6:0];
        dc_q     <= dc_i;
        bit_q    <= '0;
        div_q    <= '0;
      end
    end else if (setup_q) begin
      // mosi has had a full cycle of setup; start the first high phase
      setup_q <= 1'b0;
      sclk_q  <= 1'b1;
    end else if (div_q != DIV_LAST) begin
      div_q <= div_q + 8'd1;
    end else begin
      div_q <= '0;
      if (sclk_q) begin
        sclk_q <= 1'b0;
        if (bit_q != 3'd7) begin
          mosi_q  <= shreg_q[6];
          shreg_q <= {shreg_q[5:0], 1'b0};
        end
      end else if (bit_q == 3'd7) begin
        active_q <= 1'b0;
      end else begin
        bit_q  <= bit_q + 3'd1;
        sclk_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_frame_streamer.sv
// Streams one framebuffer half to an SSD1306 over 4-wire SPI: window preamble then page-major data.
// Latency: per data byte FETCH, WAIT, then 2 + 16*CLK_DIV cycles of SHIFT; no fetch/shift overlap.
// start_frame is only taken in IDLE and never queued. OLED_INIT_SEQ_EN adds a once-per-reset init burst.
module oled_frame_streamer
  import sr1_gpu_pkg::*;
  #(
  parameter int CLK_DIV   = 2,
  parameter int NUM_COLS  = FB_COLS,
  parameter int NUM_PAGES = FB_ROWS / 8
  )
  (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_frame,
  input  logic [7:0]           frame_data,
  output logic [FB_ADDR_W-1:0] frame_address,
  output logic                 send_next_data,
  output logic                 page01,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  output logic                 spi_cs_n,
  output logic                 spi_dc,
  output logic                 busy,
  output logic                 frame_done
  );

  localparam logic [7:0]  LAST_COL_B  = 8'(NUM_COLS - 1);
  localparam logic [7:0]  LAST_PAGE_B = 8'(NUM_PAGES - 1);
  localparam logic [10:0] LAST_COL    = 11'(NUM_COLS - 1);
  localparam logic [10:0] LAST_PAGE   = 11'(NUM_PAGES - 1);

  state_t               state_q;
  logic [2:0]           idx_q;
  logic                 sent_q;
  logic [10:0]          col_q, page_q, col_d, page_d;
  logic                 last_byte;
  logic [FB_ADDR_W-1:0] addr_q;
  logic                 strobe_q, page01_q, cs_n_q, busy_q, done_q;
  logic                 tx_load_q, tx_dc_q, tx_done;
  logic [7:0]           tx_byte_q;
`ifdef OLED_INIT_SEQ_EN
  logic                 init_done_q;
`endif

  assign frame_address  = addr_q;
  assign send_next_data = strobe_q;
  assign page01         = page01_q;
  assign spi_cs_n       = cs_n_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

  // Next column/page in page-major order, and end-of-frame detect
  always_comb begin
    col_d     = col_q + 11'd1;
    page_d    = page_q;
    last_byte = (col_q == LAST_COL) && (page_q == LAST_PAGE);
    if (col_q == LAST_COL) begin
      col_d  = '0;
      page_d = page_q + 11'd1;
    end
  end

  // Frame sequencer with registered strobes and SPI framing outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sent_q    <= 1'b0;
      col_q     <= '0;
      page_q    <= '0;
      addr_q    <= '0;
      strobe_q  <= 1'b0;
      page01_q  <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_load_q <= 1'b0;
      tx_dc_q   <= 1'b0;
      tx_byte_q <= '0;
`ifdef OLED_INIT_SEQ_EN
      init_done_q <= 1'b0;
`endif
    end else begin
      strobe_q  <= 1'b0;
      tx_load_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_frame) begin
            busy_q <= 1'b1;
            cs_n_q <= 1'b0;
            idx_q  <= '0;
            sent_q <= 1'b0;
            col_q  <= '0;
            page_q <= '0;
`ifdef OLED_INIT_SEQ_EN
            state_q <= init_done_q ? CMD : INIT;
`else
            state_q <= CMD;
`endif
          end
        end
        INIT: begin
`ifdef OLED_INIT_SEQ_EN
          if (!sent_q) begin
            tx_load_q <= 1'b1;
            tx_byte_q <= init_byte(idx_q);
            tx_dc_q   <= 1'b0;
            sent_q    <= 1'b1;
          end else if (tx_done) begin
            sent_q <= 1'b0;
            if (idx_q == 3'(INIT_LEN - 1)) begin
              idx_q       <= '0;
              init_done_q <= 1'b1;
              state_q     <= CMD;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
`else
          state_q <= CMD;
`endif
        end
        CMD: begin
          if (!sent_q) begin
            tx_load_q <= 1'b1;
            tx_byte_q <= cmd_byte(idx_q, LAST_COL_B, LAST_PAGE_B);
            tx_dc_q   <= 1'b0;
            sent_q    <= 1'b1;
          end else if (tx_done) begin
            sent_q <= 1'b0;
            if (idx_q == 3'(CMD_LEN - 1)) begin
              idx_q    <= '0;
              addr_q   <= fb_addr(col_q, page_q);
              strobe_q <= 1'b1;
              state_q  <= FETCH;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        FETCH: state_q <= WAIT;
        WAIT: begin
          // Read data for the strobed address is valid this cycle
          tx_load_q <= 1'b1;
          tx_byte_q <= frame_data;
          tx_dc_q   <= 1'b1;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (tx_done) begin
            if (last_byte) begin
              cs_n_q   <= 1'b1;
              page01_q <= ~page01_q;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= DONE;
            end else begin
              col_q    <= col_d;
              page_q   <= page_d;
              addr_q   <= fb_addr(col_d, page_d);
              strobe_q <= 1'b1;
              state_q  <= FETCH;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk    (clk),
    .reset  (reset),
    .load_i (tx_load_q),
    .byte_i (tx_byte_q),
    .dc_i   (tx_dc_q),
    .done_o (tx_done),
    .sclk_o (spi_sclk),
    .mosi_o (spi_mosi),
    .dc_o   (spi_dc)
  );

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench for oled_frame_streamer at CLK_DIV=2, 128x8 pages; decodes the SPI bus back into bytes.
// Framebuffer model returns addr[7:0] one cycle after each read strobe.
// Honours OLED_INIT_SEQ_EN when the same macro is defined for the build.
module tb_oled_frame_streamer;

  localparam int CLK_DIV = 2;
  // First rising to last falling sclk within a byte: 15 half-periods of 2 cycles
  localparam int SPAN = 30;
`ifdef OLED_INIT_SEQ_EN
  localparam int NINIT = 5;
`else
  localparam int NINIT = 0;
`endif
  localparam logic [7:0] PRE_EXP  [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
  localparam logic [7:0] INIT_EXP [5] = '{8'h8D, 8'h14, 8'h20, 8'h00, 8'hAF};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_frame = 1'b0;
  logic [7:0] frame_data = 8'h00;
  logic [9:0] frame_address;
  logic       send_next_data, page01, spi_sclk, spi_mosi, spi_cs_n, spi_dc, busy, frame_done;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  oled_frame_streamer #(.CLK_DIV(CLK_DIV), .NUM_COLS(128), .NUM_PAGES(8)) dut (
    .clk(clk), .reset(reset), .start_frame(start_frame), .frame_data(frame_data),
    .frame_address(frame_address), .send_next_data(send_next_data), .page01(page01),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_dc(spi_dc),
    .busy(busy), .frame_done(frame_done)
  );

  // Framebuffer: byte content equals the low address bits
  always @(posedge clk) if (send_next_data) frame_data <= frame_address[7:0];

  // SPI decoder and strobe monitor
  logic [7:0] rx_b [$];
  logic       rx_dc [$];
  int         rx_span [$];
  logic [9:0] addrs [$];
  int cyc = 0, bit_n = 0, t_first = 0, hi_run = 0, hi_bad = 0, done_cnt = 0;
  int min_gap = 1000000, last_strobe = -1, addr_unstable = 0;
  logic sclk_prev = 1'b0, dc_l = 1'b0;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      bit_n = 0; sclk_prev = 1'b0; hi_run = 0;
    end else begin
      if (spi_sclk) hi_run++;
      else if (sclk_prev) begin
        if (hi_run != CLK_DIV) hi_bad++;
        hi_run = 0;
      end
      if (spi_sclk && !sclk_prev) begin
        if (bit_n == 0) t_first = cyc;
        sh = {sh[6:0], spi_mosi};
        dc_l = spi_dc;
        bit_n++;
      end
      if (!spi_sclk && sclk_prev && bit_n == 8) begin
        rx_b.push_back(sh); rx_dc.push_back(dc_l); rx_span.push_back(cyc - t_first);
        bit_n = 0;
      end
      if (send_next_data) begin
        if (last_strobe >= 0 && cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
        last_strobe = cyc;
        addrs.push_back(frame_address);
      end else if (addrs.size() > 0 && frame_address != addrs[addrs.size()-1]) begin
        addr_unstable++;
      end
      if (frame_done) done_cnt++;
      sclk_prev = spi_sclk;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_mon();
    rx_b.delete(); rx_dc.delete(); rx_span.delete(); addrs.delete();
    done_cnt = 0; hi_bad = 0; min_gap = 1000000; last_strobe = -1; addr_unstable = 0;
  endtask

  task automatic pulse_start();
    start_frame = 1'b1; step(1); start_frame = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int k = 0;
    while (rx_b.size() < n && k < budget) begin step(1); k++; end
    ok = (rx_b.size() >= n);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin step(1); k++; end
    ok = (done_cnt > 0);
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    int k = 0;
    while (addrs.size() < n && k < budget) begin step(1); k++; end
    ok = (addrs.size() >= n);
  endtask

  // {sclk, mosi, cs_n, dc, busy, frame_done, send_next_data, page01}
  task automatic test_reset();
    reset = 1'b1; step(3);
    n_chk++;
    if ({spi_sclk, spi_mosi, spi_cs_n, spi_dc, busy, frame_done, send_next_data, page01} !== 8'b0010_0000)
      $display("FAIL reset_outs: got %b want 00100000",
               {spi_sclk, spi_mosi, spi_cs_n, spi_dc, busy, frame_done, send_next_data, page01});
    else n_pass++;
    n_chk++;
    if (frame_address !== 10'd0) $display("FAIL reset_addr: got %0d want 0", frame_address);
    else n_pass++;
    reset = 1'b0; step(2);
  endtask

  task automatic test_preamble();
    bit ok;
    logic [7:0] e;
    clear_mon(); pulse_start();
    n_chk++;
    if ({busy, spi_cs_n} !== 2'b10) $display("FAIL accept: busy,cs_n got %b want 10", {busy, spi_cs_n});
    else n_pass++;
    wait_bytes(NINIT + 6, 2000, ok);
    n_chk++;
    if (!ok) $display("FAIL preamble_timeout: got %0d bytes want %0d", rx_b.size(), NINIT + 6);
    else n_pass++;
    if (ok) begin
      for (int i = 0; i < NINIT + 6; i++) begin
        e = (i < NINIT) ? INIT_EXP[i] : PRE_EXP[i - NINIT];
        n_chk++;
        if ({rx_dc[i], rx_b[i]} !== {1'b0, e})
          $display("FAIL pre_byte%0d: got dc=%b %h want dc=0 %h", i, rx_dc[i], rx_b[i], e);
        else n_pass++;
        n_chk++;
        if (rx_span[i] != SPAN) $display("FAIL pre_span%0d: got %0d want %0d", i, rx_span[i], SPAN);
        else n_pass++;
      end
    end
  endtask

  task automatic test_address_order();
    bit ok;
    int errs;
    logic [9:0] a, ea;
    int ks [5] = '{0, 1, 2, 128, 1023};
    int ev [5] = '{0, 8, 16, 1, 1023};
    wait_done(40000, ok);
    n_chk++;
    if (!ok) $display("FAIL frame1_timeout: got done_cnt %0d want 1", done_cnt);
    else n_pass++;
    n_chk++;
    if (addrs.size() != 1024) $display("FAIL strobe_count: got %0d want 1024", addrs.size());
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      a = (addrs.size() > ks[i]) ? addrs[ks[i]] : 'x;
      n_chk++;
      if (a !== 10'(ev[i])) $display("FAIL addr_of_byte%0d: got %0d want %0d", ks[i] + 1, a, ev[i]);
      else n_pass++;
    end
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      ea = 10'((i % 128) * 8 + i / 128);
      if (NINIT + 6 + i >= rx_b.size()) errs++;
      else if ({rx_dc[NINIT+6+i], rx_b[NINIT+6+i]} !== {1'b1, ea[7:0]}) errs++;
    end
    n_chk++;
    if (errs != 0) $display("FAIL data_bytes: got %0d bad bytes want 0", errs);
    else n_pass++;
    n_chk++;
    if (min_gap < 3) $display("FAIL strobe_gap: got %0d want >=3", min_gap);
    else n_pass++;
    n_chk++;
    if (addr_unstable != 0) $display("FAIL addr_hold: got %0d changes want 0", addr_unstable);
    else n_pass++;
    n_chk++;
    if (hi_bad != 0) $display("FAIL sclk_high: got %0d bad high phases want 0", hi_bad);
    else n_pass++;
  endtask

  // Called in the DONE cycle straight after test_address_order
  task automatic test_frame_end();
    n_chk++;
    if ({frame_done, page01, spi_cs_n, busy} !== 4'b1110)
      $display("FAIL frame_end: done,page01,cs_n,busy got %b want 1110", {frame_done, page01, spi_cs_n, busy});
    else n_pass++;
    step(5);
    n_chk++;
    if ({done_cnt, frame_done} !== {32'd1, 1'b0})
      $display("FAIL done_pulse: got count %0d level %b want 1 0", done_cnt, frame_done);
    else n_pass++;
    n_chk++;
    if (rx_b.size() != NINIT + 1030) $display("FAIL frame1_bytes: got %0d want %0d", rx_b.size(), NINIT + 1030);
    else n_pass++;
  endtask

  // Second frame with start_frame held high throughout, including the frame_done cycle
  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    start_frame = 1'b1;
    wait_done(40000, ok);
    start_frame = 1'b0;
    n_chk++;
    if (!ok) $display("FAIL frame2_timeout: got done_cnt %0d want 1", done_cnt);
    else n_pass++;
    n_chk++;
    if (page01 !== 1'b0) $display("FAIL page01_toggle_back: got %b want 0", page01);
    else n_pass++;
    n_chk++;
    if ((rx_b.size() > 0 ? rx_b[0] : 8'hxx) !== 8'h21)
      $display("FAIL frame2_first: got %h want 21", rx_b.size() > 0 ? rx_b[0] : 8'hxx);
    else n_pass++;
    step(100);
    n_chk++;
    if (rx_b.size() != 1030) $display("FAIL frame2_bytes: got %0d want 1030", rx_b.size());
    else n_pass++;
    n_chk++;
    if ({busy, spi_cs_n} !== 2'b01) $display("FAIL no_restart: busy,cs_n got %b want 01", {busy, spi_cs_n});
    else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    clear_mon(); pulse_start();
    wait_strobes(100, 6000, ok);
    n_chk++;
    if (!ok) $display("FAIL byte100_timeout: got %0d strobes want 100", addrs.size());
    else n_pass++;
    step(10);
    reset = 1'b1; #1;
    n_chk++;
    if ({spi_sclk, spi_mosi, spi_cs_n, spi_dc, busy, frame_done, send_next_data, page01} !== 8'b0010_0000)
      $display("FAIL midreset_outs: got %b want 00100000",
               {spi_sclk, spi_mosi, spi_cs_n, spi_dc, busy, frame_done, send_next_data, page01});
    else n_pass++;
    n_chk++;
    if (frame_address !== 10'd0) $display("FAIL midreset_addr: got %0d want 0", frame_address);
    else n_pass++;
    step(2);
    reset = 1'b0; step(1);
    clear_mon(); pulse_start();
    wait_bytes(1, 300, ok);
    n_chk++;
    if (!ok || {rx_dc[0], rx_b[0]} !== {1'b0, (NINIT > 0) ? 8'h8D : 8'h21})
      $display("FAIL restart_first: got ok=%b %h want %h", ok, ok ? rx_b[0] : 8'h00,
               (NINIT > 0) ? 8'h8D : 8'h21);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_preamble();
    test_address_order();
    test_frame_end();
    test_back_to_back();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/oled_frame_streamer.md
OLED_FRAME_STREAMER -- requirements
Module: oled_frame_streamer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning SCLK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter NUM_COLS, default 128, meaning display columns.
REQ-003 SHALL have parameter NUM_PAGES, default 8, meaning 8-pixel-tall display pages.
REQ-004 SHALL have port clk input 1, system clock.
REQ-005 SHALL have port reset input 1, asynchronous, active-high.
REQ-006 SHALL have port start_frame input 1, single-cycle request to stream one frame.
REQ-007 SHALL have port frame_data input 8, framebuffer read data, valid one cycle after send_next_data.
REQ-008 SHALL have port frame_address output 10, framebuffer read address.
REQ-009 SHALL have port send_next_data output 1, one-cycle framebuffer read strobe (read-and-clear).
REQ-010 SHALL have port page01 output 1, selects the framebuffer half being displayed.
REQ-011 SHALL have ports spi_sclk, spi_mosi, spi_cs_n, spi_dc, each output 1, SSD1306-style 4-wire SPI.
REQ-012 SHALL have port busy output 1, high from start_frame acceptance until frame end.
REQ-013 SHALL have port frame_done output 1, one-cycle pulse at frame end.

Function
REQ-014 SHALL use FSM states IDLE, INIT, CMD, FETCH, WAIT, SHIFT, DONE.
REQ-015 SHALL accept start_frame only in IDLE; it is ignored in all other states.
REQ-016 SHALL on acceptance assert busy, drive spi_cs_n low, and enter CMD (or INIT per REQ-027).
REQ-017 SHALL in CMD send, with spi_dc=0, the 6 bytes 0x21,0x00,NUM_COLS-1,0x22,0x00,NUM_PAGES-1 in order.
REQ-018 SHALL then stream NUM_COLS*NUM_PAGES data bytes with spi_dc=1, page-major order: page p = 0..NUM_PAGES-1 outer, column c = 0..NUM_COLS-1 inner.
REQ-019 SHALL per data byte pulse send_next_data for one cycle in FETCH with frame_address = c*8 + p (10 bits, truncating), enter WAIT, and capture frame_data in the following cycle.
REQ-020 SHALL hold frame_address stable from its strobe until the next strobe, which is at least 3 cycles later (the framebuffer clear write lands on that address).
REQ-021 SHALL shift bytes in SPI mode 0: MSB first, sclk idle low, mosi updated while sclk low, sclk high for CLK_DIV cycles then low for CLK_DIV cycles per bit, i.e. 16*CLK_DIV cycles per byte.
REQ-022 SHALL overlap no fetch with the shift of the previous byte: the sequence is strictly FETCH, WAIT, SHIFT.
REQ-023 SHALL after the last data bit enter DONE: raise spi_cs_n, toggle page01, pulse frame_done, drop busy, and return to IDLE in the next cycle.
REQ-024 SHALL accept a start_frame arriving in the same cycle as frame_done only in the following cycle when re-presented (it is not queued).

Reset
REQ-025 SHALL on reset assertion immediately set state IDLE, frame_address 0, send_next_data 0, page01 0, spi_sclk 0, spi_mosi 0, spi_cs_n 1, spi_dc 0, busy 0, frame_done 0, and clear byte/bit/column/page counters.
REQ-026 SHALL abandon any transfer in progress on reset with no page01 toggle; the first frame after reset restarts from the preamble.

Configuration
REQ-027 SHALL, when OLED_INIT_SEQ_EN is defined, send once after reset, on the first accepted start_frame and before CMD, the dc=0 bytes 0x8D,0x14,0x20,0x00,0xAF in state INIT; without OLED_INIT_SEQ_EN, INIT is absent and CMD follows acceptance directly.

Structure
REQ-028 SHALL place the FSM state enum, command byte constants, init sequence constants, and FB geometry (128x64, 1024 B per page) in shared package sr1_gpu_pkg.
REQ-029 SHALL implement bit serialisation in one sub-module spi_byte_tx (load/byte/dc in, done pulse out); address, counter, and FSM logic stay in the top module.

Verification
REQ-030 SHALL test reset mid-stream: assert reset during data byte 100 -> all outputs at reset values within the same cycle; page01 stays 0.
REQ-031 SHALL test the preamble (CLK_DIV=2, no macro): start_frame -> spi_cs_n falls; 6 dc=0 bytes 0x21,0x00,0x7F,0x22,0x00,0x07, each 32 cycles of sclk.
REQ-032 SHALL test address order: model FB byte = addr[7:0] -> data bytes 1..3 read addresses 0,8,16 and byte 129 reads address 1; data byte 1024 reads address 1023.
REQ-033 SHALL test frame end: after 1030 bytes -> frame_done pulses once, page01 0->1, spi_cs_n 1, busy 0; second frame toggles page01 back to 0.
REQ-034 SHALL test start_frame held high continuously during a frame -> no restart and no extra bytes; exactly 1030 bytes per frame.
REQ-035 SHALL test the OLED_INIT_SEQ_EN build: first frame is preceded by 0x8D,0x14,0x20,0x00,0xAF; the second frame starts directly at 0x21.
